// File: rtl/keypad_entry_if.sv
// Result handshake between the keypad entry block and the CPU's MMIO input port.
interface keypad_entry_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/keypad_entry.sv
// Keypad key-code filter, decimal entry editor and serial BCD-to-binary converter
// feeding a valid/ready result port.
module keypad_entry #(
    parameter int         MAX_DIGITS    = 8,
    parameter int         STABLE_CYCLES = 16,
    parameter logic [3:0] ENTER_KEY     = 4'hF,
    parameter logic [3:0] BKSP_KEY      = 4'hE,
    parameter logic [3:0] CLEAR_KEY     = 4'hA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           key_in,
    keypad_entry_if.master       cpu,
    output logic [31:0]          bcd,
    output logic [3:0]           digit_cnt,
    output logic                 busy,
    output logic                 full
);
    localparam logic [4:0] NO_KEY = 5'b10000;
    localparam int         CW     = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {ENTRY, CONVERT, HOLD} state_t;

    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    filt_q, filt_d;
    logic          ev_q, ev_d;
    logic [3:0]    ev_key_q, ev_key_d;

    state_t        state_q, state_d;
    logic [31:0]   bcd_q, bcd_d;
    logic [3:0]    digit_cnt_q, digit_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;

    logic [31:0]   acc_next;
    logic [31:0]   dig_shift;

    // Input filter: a code becomes the filtered code once seen STABLE_CYCLES times in a row
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (cnt_d == CW'(STABLE_CYCLES))
            filt_d = cand_d;
        ev_d     = filt_q[4] & ~filt_d[4];
        ev_key_d = filt_d[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= NO_KEY;
            sync2_q  <= NO_KEY;
            cand_q   <= NO_KEY;
            cnt_q    <= '0;
            filt_q   <= NO_KEY;
            ev_q     <= 1'b0;
            ev_key_q <= 4'h0;
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
            ev_q     <= ev_d;
            ev_key_q <= ev_key_d;
        end
    end

    // Oldest digit sits at nibble digit_cnt-1; idx walks it down to nibble 0
    assign dig_shift = bcd_q >> {idx_q, 2'b00};
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + {28'h0, dig_shift[3:0]};

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        digit_cnt_d = digit_cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ENTRY: begin
                if (ev_q) begin
                    if (ev_key_q == ENTER_KEY) begin
                        if (digit_cnt_q != 4'd0) begin
                            acc_d   = '0;
                            idx_d   = 3'(digit_cnt_q - 4'd1);
                            state_d = CONVERT;
                        end
                    end else if (ev_key_q == BKSP_KEY) begin
                        bcd_d = bcd_q >> 4;
                        if (digit_cnt_q != 4'd0)
                            digit_cnt_d = digit_cnt_q - 4'd1;
                    end else if (ev_key_q == CLEAR_KEY) begin
                        bcd_d       = '0;
                        digit_cnt_d = '0;
                    end else if (ev_key_q < 4'd10 && digit_cnt_q < 4'(MAX_DIGITS)) begin
                        bcd_d       = {bcd_q[27:0], ev_key_q};
                        digit_cnt_d = digit_cnt_q + 4'd1;
                    end
                end
            end
            CONVERT: begin
                acc_d = acc_next;
                if (idx_q == 3'd0) begin
                    out_data_d  = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            HOLD: begin
                if (cpu.out_ready) begin
                    out_valid_d = 1'b0;
                    bcd_d       = '0;
                    digit_cnt_d = '0;
                    state_d     = ENTRY;
                end
            end
            default: state_d = ENTRY;
        endcase
        busy_d = (state_d != ENTRY);
        full_d = (digit_cnt_d == 4'(MAX_DIGITS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTRY;
            bcd_q       <= '0;
            digit_cnt_q <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            digit_cnt_q <= digit_cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
        end
    end

    assign cpu.out_data  = out_data_q;
    assign cpu.out_valid = out_valid_q;
    assign bcd           = bcd_q;
    assign digit_cnt     = digit_cnt_q;
    assign busy          = busy_q;
    assign full          = full_q;
endmodule
